pe_fma_pipe: RTL

//   Parametrised fixed-point processing element for the NoC matrix datapath; computes C -/+ (A*B) per issued op.

---
 rtl/pe_fma_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pe_fma_pipe.sv
// pe_fma_pipe: pipelined fixed-point fused multiply-add/subtract element.
//   Computes C + (A*B) or C - (A*B) on signed Q(WIDTH-FRAC).FRAC operands.
//   The mult section has MULT_LAT register stages and the add section has
//   ADD_LAT register stages. C, op_sub and the tag travel alongside the
//   product, so every op sees its own C.
//   Optional build macro PE_SATURATE_EN: when it is defined, narrowing
//   saturates. When it is undefined, narrowing wraps. add_ovf is reported
//   the same way in both builds.
//
// Valid semantics: an op enters when en=1 and in_valid=1 at a rising edge.
//   There is no backpressure. en=0 freezes every register, inputs included.
//   mult_valid and add_valid mark the cycles in which the matching data,
//   tag and ovf outputs belong to a real op.
module pe_fma_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int MULT_LAT = 4,
  parameter int ADD_LAT  = 2,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             mult_valid,
  output logic [WIDTH-1:0] mult_result,
  output logic [TAG_W-1:0] mult_tag,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_result,
  output logic [TAG_W-1:0] add_tag,
  output logic             add_ovf,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int ML = MULT_LAT - 1;
  localparam int AL = ADD_LAT - 1;

`ifdef PE_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // ---------------- mult section: full product, scale, narrow ----------------
  logic signed [PW-1:0]  a_ext, b_ext, prod_full, prod_scaled;
  logic        [WIDTH:0] s_top;
  logic                  m_ovf_d;
  logic [WIDTH-1:0]      m_res_d;

  assign a_ext       = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext       = {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_full   = a_ext * b_ext;
  // The arithmetic shift truncates toward minus infinity.
  assign prod_scaled = prod_full >>> FRAC;
  // The scaled product fits in WIDTH bits only when all bits above WIDTH-1 copy the sign.
  assign s_top       = prod_scaled[PW-1:WIDTH-1];
  assign m_ovf_d     = ~((&s_top) | ~(|s_top));

`ifdef PE_SATURATE_EN
  assign m_res_d = m_ovf_d ? (prod_scaled[PW-1] ? MIN_NEG : MAX_POS) : prod_scaled[WIDTH-1:0];
`else
  assign m_res_d = prod_scaled[WIDTH-1:0];
`endif

  logic [MULT_LAT-1:0] m_valid_q;
  logic [MULT_LAT-1:0] m_ovf_q;
  logic [MULT_LAT-1:0] m_sub_q;
  logic [WIDTH-1:0]    m_res_q [MULT_LAT];
  logic [WIDTH-1:0]    m_c_q   [MULT_LAT];
  logic [TAG_W-1:0]    m_tag_q [MULT_LAT];

  // Mult delay line: stage 0 captures the narrowed product and its companions, later stages shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= '0;
      m_ovf_q   <= '0;
      m_sub_q   <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        m_res_q[i] <= '0;
        m_c_q[i]   <= '0;
        m_tag_q[i] <= '0;
      end
    end else if (en) begin
      m_valid_q[0] <= in_valid;
      m_ovf_q[0]   <= m_ovf_d;
      m_sub_q[0]   <= op_sub;
      m_res_q[0]   <= m_res_d;
      m_c_q[0]     <= C;
      m_tag_q[0]   <= in_tag;
      for (int i = 1; i < MULT_LAT; i++) begin
        m_valid_q[i] <= m_valid_q[i-1];
        m_ovf_q[i]   <= m_ovf_q[i-1];
        m_sub_q[i]   <= m_sub_q[i-1];
        m_res_q[i]   <= m_res_q[i-1];
        m_c_q[i]     <= m_c_q[i-1];
        m_tag_q[i]   <= m_tag_q[i-1];
      end
    end
  end

  // ---------------- add section: C -/+ narrowed product ----------------
  logic signed [WIDTH:0] c_ext, m_ext, sum_full;
  logic                  a_ovf_d;
  logic [WIDTH-1:0]      a_res_d;

  assign c_ext    = {m_c_q[ML][WIDTH-1], m_c_q[ML]};
  assign m_ext    = {m_res_q[ML][WIDTH-1], m_res_q[ML]};
  assign sum_full = m_sub_q[ML] ? (c_ext - m_ext) : (c_ext + m_ext);
  assign a_ovf_d  = m_ovf_q[ML] | (sum_full[WIDTH] ^ sum_full[WIDTH-1]);

`ifdef PE_SATURATE_EN
  assign a_res_d = (sum_full[WIDTH] ^ sum_full[WIDTH-1]) ?
                   (sum_full[WIDTH] ? MIN_NEG : MAX_POS) : sum_full[WIDTH-1:0];
`else
  assign a_res_d = sum_full[WIDTH-1:0];
`endif

  logic [ADD_LAT-1:0] a_valid_q;
  logic [ADD_LAT-1:0] a_ovf_q;
  logic [WIDTH-1:0]   a_res_q [ADD_LAT];
  logic [TAG_W-1:0]   a_tag_q [ADD_LAT];

  // Add delay line: stage 0 captures the sum of the last mult stage, later stages shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= '0;
      a_ovf_q   <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        a_res_q[i] <= '0;
        a_tag_q[i] <= '0;
      end
    end else if (en) begin
      a_valid_q[0] <= m_valid_q[ML];
      a_ovf_q[0]   <= a_ovf_d;
      a_res_q[0]   <= a_res_d;
      a_tag_q[0]   <= m_tag_q[ML];
      for (int i = 1; i < ADD_LAT; i++) begin
        a_valid_q[i] <= a_valid_q[i-1];
        a_ovf_q[i]   <= a_ovf_q[i-1];
        a_res_q[i]   <= a_res_q[i-1];
        a_tag_q[i]   <= a_tag_q[i-1];
      end
    end
  end

  assign mult_valid  = m_valid_q[ML];
  assign mult_result = m_res_q[ML];
  assign mult_tag    = m_tag_q[ML];
  assign add_valid   = a_valid_q[AL];
  assign add_result  = a_res_q[AL];
  assign add_tag     = a_tag_q[AL];
  assign add_ovf     = a_ovf_q[AL];
  assign busy        = (|m_valid_q) | (|a_valid_q);

endmodule
